// File: rtl/vga_user_pio_out.sv
// vga_user_pio_out: Avalon-MM output PIO with shadow register and vsync-aligned commit.
// Define VGA_USER_PIO_OUT_IRQ_EN to add the IRQ_MASK bit and the registered irq output.
module vga_user_pio_out #(
  parameter int                    DATA_WIDTH       = 22,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE      = '0,
  parameter bit                    VSYNC_ACTIVE_LOW = 1'b1,
  parameter int                    SYNC_STAGES      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  vsync_in,
`ifdef VGA_USER_PIO_OUT_IRQ_EN
  output logic                  irq,
`endif
  output logic [DATA_WIDTH-1:0] out_port
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_vs_d;
  logic [DATA_WIDTH-1:0]  r_shadow;
  logic [DATA_WIDTH-1:0]  r_out;
  logic                   r_pend;
  logic                   r_imm;
  logic                   r_imm_due;
  logic                   r_done;
  logic [15:0]            r_count;
  logic [31:0]            r_rd;

  logic        w_wr;
  logic        w_wr_sh;
  logic        w_wr_ctl;
  logic        w_wr_cnt;
  logic        w_force;
  logic        w_vs;
  logic        w_vedge;
  logic        w_commit;
  logic        w_mask;
  logic [31:0] w_ctl;
  logic [31:0] w_rd;
  logic        w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wr_sh  = w_wr & (address == 2'd0);
  assign w_wr_ctl = w_wr & (address == 2'd2);
  assign w_wr_cnt = w_wr & (address == 2'd3);
  assign w_force  = w_wr_ctl & writedata[2];

  assign w_vs    = r_sync[SYNC_STAGES-1];
  assign w_vedge = VSYNC_ACTIVE_LOW ? (r_vs_d & ~w_vs)
                                    : (~r_vs_d & w_vs);

  // A vsync edge and FORCE together still make one commit.
  assign w_commit = (r_pend & w_vedge) | r_imm_due | w_force;

  assign w_ctl    = {27'd0, w_mask, r_done, 1'b0, r_pend, r_imm};
  assign w_unused = &{1'b0, writedata};

  always_comb begin
    w_rd = '0;
    unique case (address)
      2'd0: w_rd = 32'(r_shadow);
      2'd1: w_rd = 32'(r_out);
      2'd2: w_rd = w_ctl;
      2'd3: w_rd = {16'd0, r_count};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= {SYNC_STAGES{VSYNC_ACTIVE_LOW}};
      r_vs_d <= VSYNC_ACTIVE_LOW;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], vsync_in};
      r_vs_d <= w_vs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow  <= RESET_VALUE;
      r_out     <= RESET_VALUE;
      r_pend    <= 1'b0;
      r_imm     <= 1'b0;
      r_imm_due <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_rd      <= '0;
    end else begin
      r_rd      <= w_rd;
      r_imm_due <= w_wr_sh & r_imm;
      if (w_commit)
        r_out <= r_shadow;
      if (w_wr_sh)
        r_shadow <= writedata[DATA_WIDTH-1:0];
      // A new write keeps pending set even if the old value commits now.
      if (w_wr_sh)
        r_pend <= 1'b1;
      else if (w_commit)
        r_pend <= 1'b0;
      if (w_wr_ctl)
        r_imm <= writedata[0];
      if (w_commit)
        r_done <= 1'b1;
      else if (w_wr_ctl & writedata[3])
        r_done <= 1'b0;
      if (w_wr_cnt)
        r_count <= {15'd0, w_commit};
      else if (w_commit)
        r_count <= r_count + 16'd1;
    end
  end

`ifdef VGA_USER_PIO_OUT_IRQ_EN
  logic r_mask;
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr_ctl)
        r_mask <= writedata[4];
      r_irq <= r_done & r_mask;
    end
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = 1'b0;
`endif

  assign readdata = r_rd;
  assign out_port = r_out;

endmodule

// File: tb/tb_vga_user_pio_out.sv
// tb_vga_user_pio_out: directed stimulus, cycle model of the register map,
// per-cycle compare of out_port/readdata(/irq) plus literal spot checks.
module tb_vga_user_pio_out;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        vsync_in = 1'b1;
  logic [21:0] out_port;
`ifdef VGA_USER_PIO_OUT_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_user_pio_out dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .vsync_in  (vsync_in),
`ifdef VGA_USER_PIO_OUT_IRQ_EN
    .irq       (irq),
`endif
    .out_port  (out_port)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: the register map as plain variables.
  logic [21:0] m_shadow = '0;
  logic [21:0] m_out = '0;
  bit          m_pend, m_imm, m_done, m_mask, m_due, m_irq;
  logic [15:0] m_count = '0;
  logic [31:0] m_rd = '0;
  bit          pin_q[$];

  function automatic logic [31:0] m_read(logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_shadow);
      2'd1:    return 32'(m_out);
      2'd2:    return {27'd0, m_mask, m_done, 1'b0, m_pend, m_imm};
      default: return {16'd0, m_count};
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    bit wr, fire, vedge;
    if (!reset_n) begin
      m_shadow = '0; m_out = '0; m_count = '0; m_rd = '0;
      m_pend = 0; m_imm = 0; m_done = 0;
      m_mask = 0; m_due = 0; m_irq = 0;
      pin_q = '{1'b1, 1'b1, 1'b1};
    end else begin
      wr = chipselect && !write_n;
      m_rd = m_read(address);
      // A falling pin level is acted on at the 3rd edge after first sampled.
      vedge = pin_q[0] && !pin_q[1];
      pin_q.push_back(vsync_in);
      void'(pin_q.pop_front());
      fire = (m_pend && vedge) || m_due
          || (wr && address == 2'd2 && writedata[2]);
      m_irq = m_done && m_mask;
      m_due = wr && address == 2'd0 && m_imm;
      if (fire) begin
        m_out = m_shadow;
        m_pend = 0;
        m_done = 1;
        m_count = m_count + 16'd1;
      end
      if (wr) begin
        case (address)
          2'd0: begin
            m_shadow = writedata[21:0];
            m_pend = 1;
          end
          2'd2: begin
            m_imm = writedata[0];
`ifdef VGA_USER_PIO_OUT_IRQ_EN
            m_mask = writedata[4];
`endif
            if (writedata[3] && !fire)
              m_done = 0;
          end
          2'd3: m_count = fire ? 16'd1 : 16'd0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_out_port", 32'(out_port), 32'(m_out));
    chk("cyc_readdata", readdata, m_rd);
`ifdef VGA_USER_PIO_OUT_IRQ_EN
    chk("cyc_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    step();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] exp, string nm);
    address = a;
    step();
    chk(nm, readdata, exp);
  endtask

  task automatic vs_fall_with(bit do_wr, logic [1:0] a, logic [31:0] d);
    vsync_in = 1'b0;
    step();
    step();
    if (do_wr)
      bus_wr(a, d);
    else
      step();
  endtask

  task automatic vs_rise();
    vsync_in = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    repeat (3) step();
    chk("reset_out", 32'(out_port), 32'h0);
    chk("reset_rd", readdata, 32'h0);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++)
      rd(2'(i), 32'h0, "reset_regs");

    // Sync mode: held until a vsync edge.
    bus_wr(2'd0, 32'h2A5A5);
    repeat (100) step();
    chk("sync_held", 32'(out_port), 32'h0);
    rd(2'd2, 32'h2, "pending_set");
    vsync_in = 1'b0;
    step();
    step();
    chk("vs_latency_pre", 32'(out_port), 32'h0);
    step();
    chk("vs_commit", 32'(out_port), 32'h2A5A5);
    rd(2'd2, 32'h8, "done_set");
    rd(2'd3, 32'h1, "count_1");
    vs_rise();
    bus_wr(2'd1, 32'hFFFF);
    rd(2'd1, 32'h2A5A5, "active_ro");

    // Shadow write on the vsync-edge cycle.
    bus_wr(2'd0, 32'h3FFFFF);
    vs_fall_with(1'b1, 2'd0, 32'h1);
    chk("same_cyc_old", 32'(out_port), 32'h3FFFFF);
    rd(2'd0, 32'h1, "same_cyc_shadow");
    rd(2'd2, 32'hA, "same_cyc_pend");
    vs_rise();
    vs_fall_with(1'b0, 2'd0, 32'h0);
    chk("next_edge", 32'(out_port), 32'h1);
    rd(2'd3, 32'h3, "count_3");
    vs_rise();

    // Immediate mode.
    bus_wr(2'd2, 32'h8);
    rd(2'd2, 32'h0, "done_clr");
    bus_wr(2'd2, 32'h1);
    bus_wr(2'd0, 32'h155);
    chk("imm_pre", 32'(out_port), 32'h1);
    step();
    chk("imm_commit", 32'(out_port), 32'h155);
    rd(2'd3, 32'h4, "imm_count");
    rd(2'd2, 32'h9, "imm_ctrl");
    repeat (2) begin
      vs_fall_with(1'b0, 2'd0, 32'h0);
      vs_rise();
    end
    rd(2'd3, 32'h4, "imm_no_extra");

    // 0->1 IMMEDIATE with pending does not commit; FORCE does.
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd0, 32'hABC);
    bus_wr(2'd2, 32'h1);
    repeat (5) step();
    chk("imm_switch", 32'(out_port), 32'h155);
    rd(2'd2, 32'hB, "imm_switch_ctrl");
    bus_wr(2'd2, 32'h5);
    chk("force_commit", 32'(out_port), 32'hABC);
    rd(2'd3, 32'h5, "force_count");

    // FORCE on the vsync-edge cycle: one commit.
    bus_wr(2'd2, 32'h0);
    bus_wr(2'd0, 32'h12345);
    vs_fall_with(1'b1, 2'd2, 32'h4);
    chk("force_vs_out", 32'(out_port), 32'h12345);
    rd(2'd3, 32'h6, "force_vs_count");
    vs_rise();

    // DONE clear loses to a same-cycle commit.
    bus_wr(2'd2, 32'h8);
    rd(2'd2, 32'h0, "done_clr2");
    bus_wr(2'd0, 32'h54321);
    vs_fall_with(1'b1, 2'd2, 32'h8);
    rd(2'd2, 32'h8, "done_set_wins");
    vs_rise();

    // COUNT clear with a same-cycle commit leaves 1.
    bus_wr(2'd0, 32'h0F0F0);
    vs_fall_with(1'b1, 2'd3, 32'h0);
    rd(2'd3, 32'h1, "cnt_clr_commit");
    vs_rise();

    // Counter wrap.
    bus_wr(2'd3, 32'hDEAD);
    rd(2'd3, 32'h0, "cnt_clear");
    for (int i = 0; i < 65535; i++)
      bus_wr(2'd2, 32'h4);
    rd(2'd3, 32'hFFFF, "cnt_max");
    bus_wr(2'd2, 32'h4);
    rd(2'd3, 32'h0, "cnt_wrap");

`ifdef VGA_USER_PIO_OUT_IRQ_EN
    bus_wr(2'd2, 32'h18);
    step();
    chk("irq_idle", {31'd0, irq}, 32'h0);
    bus_wr(2'd2, 32'h14);
    chk("irq_pre", {31'd0, irq}, 32'h0);
    step();
    chk("irq_set", {31'd0, irq}, 32'h1);
    rd(2'd2, 32'h18, "irq_ctrl");
    bus_wr(2'd2, 32'h18);
    step();
    chk("irq_clear", {31'd0, irq}, 32'h0);
    bus_wr(2'd2, 32'h04);
    repeat (3) step();
    chk("irq_masked", {31'd0, irq}, 32'h0);
    rd(2'd2, 32'h8, "irq_mask_off");
`endif

    // Reset mid-frame discards the pending commit.
    bus_wr(2'd0, 32'h777);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    vs_fall_with(1'b0, 2'd0, 32'h0);
    step();
    chk("rst_discard", 32'(out_port), 32'h0);
    rd(2'd0, 32'h0, "rst_shadow");
    rd(2'd2, 32'h0, "rst_ctrl");
    vs_rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
